wconv_sync_fifo: RTL and testbench

Single-clock, parametrised width-converting FIFO: accepts wide words and returns them as a sequence of narrow words, generalising the 64-in/32-out transmit FIFO to any power-of-two ratio and depth. Sits in the Ethernet transmit path between the 64-bit frame builder and the 32-bit MAC feed when both share one clock. Adds occupancy counts and programmable almost-full/almost-empty thresholds.

---
 rtl/wconv_sync_fifo_if.sv | 37 +++
 rtl/wconv_sync_fifo.sv | 104 ++++++++++
 tb/tb_wconv_sync_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wconv_sync_fifo_if.sv
// Bus bundle for the width-converting FIFO: wide write side, narrow read side,
// occupancy counts and flags. Optional error flags under WCONV_ERR_FLAGS_EN.
interface wconv_sync_fifo_if #(
  parameter int DIN_W  = 64,
  parameter int DOUT_W = 32,
  parameter int WC_W   = 5,
  parameter int RC_W   = 6
);
  logic [DIN_W-1:0]  din;
  logic              wr_en;
  logic              rd_en;
  logic [DOUT_W-1:0] dout;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              almost_empty;
  logic [WC_W-1:0]   wr_count;
  logic [RC_W-1:0]   rd_count;
`ifdef WCONV_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (output din, wr_en, rd_en,
                  input  dout, full, almost_full, empty, almost_empty,
                         wr_count, rd_count, overflow, underflow);
  modport slave  (input  din, wr_en, rd_en,
                  output dout, full, almost_full, empty, almost_empty,
                         wr_count, rd_count, overflow, underflow);
`else
  modport master (output din, wr_en, rd_en,
                  input  dout, full, almost_full, empty, almost_empty,
                         wr_count, rd_count);
  modport slave  (input  din, wr_en, rd_en,
                  output dout, full, almost_full, empty, almost_empty,
                         wr_count, rd_count);
`endif
endinterface

// File: rtl/wconv_sync_fifo.sv
// Single-clock width-converting FIFO. Wide words are written whole and read
// back as RATIO narrow words, most-significant sub-word first. Occupancy is
// kept as two registered counts (wide entries held, narrow words available);
// every flag is a compare on those counts so all flags agree in a cycle.
// Optional sticky overflow/underflow flags: define WCONV_ERR_FLAGS_EN.
module wconv_sync_fifo #(
  parameter int DIN_W     = 64,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  wconv_sync_fifo_if.slave   bus
);
  localparam int DOUT_W = DIN_W / RATIO;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WC_W   = $clog2(DEPTH + 1);
  localparam int RC_W   = $clog2(DEPTH * RATIO + 1);

  logic [DIN_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [IDX_W-1:0]  r_idx;
  logic [WC_W-1:0]   r_wr_count;
  logic [RC_W-1:0]   r_rd_count;
  logic [DOUT_W-1:0] r_dout;

  logic              w_full, w_empty;
  logic              w_wr_acc, w_rd_acc, w_last, w_free;
  logic [DIN_W-1:0]  w_rd_word;
  logic [RATIO-1:0][DOUT_W-1:0] w_sub;
  logic [IDX_W-1:0]  w_sel;

  // Flags come straight from the registered counts.
  assign w_full  = (r_wr_count == WC_W'(DEPTH));
  assign w_empty = (r_rd_count == '0);

  // Acceptance uses the flags as they stand at the edge, so a write while
  // full is refused even if the same-cycle read frees an entry.
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;
  assign w_last   = (r_idx == IDX_W'(RATIO - 1));
  assign w_free   = w_rd_acc && w_last;

  // Sub-word 0 is the top slice of the wide word, so it sits in the highest
  // element of the packed view.
  assign w_rd_word = r_mem[r_rptr];
  assign w_sub     = w_rd_word;
  assign w_sel     = IDX_W'(RATIO - 1) - r_idx;

  // Storage write; data contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= bus.din;
  end

  // Pointers, sub-word index, counts and the registered read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_idx      <= '0;
      r_wr_count <= '0;
      r_rd_count <= '0;
      r_dout     <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) begin
        r_dout <= w_sub[w_sel];
        r_idx  <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_rptr <= r_rptr + 1'b1;
      end
      r_wr_count <= r_wr_count + WC_W'(w_wr_acc) - WC_W'(w_free);
      r_rd_count <= r_rd_count + (w_wr_acc ? RC_W'(RATIO) : '0) - RC_W'(w_rd_acc);
    end
  end

  assign bus.dout         = r_dout;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_wr_count >= WC_W'(AF_THRESH));
  assign bus.almost_empty = (r_rd_count <= RC_W'(AE_THRESH));
  assign bus.wr_count     = r_wr_count;
  assign bus.rd_count     = r_rd_count;

`ifdef WCONV_ERR_FLAGS_EN
  logic r_ovf, r_unf;

  // Sticky record of refused requests; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.wr_en && w_full)  r_ovf <= 1'b1;
      if (bus.rd_en && w_empty) r_unf <= 1'b1;
    end
  end

  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
`endif
endmodule

// File: tb/tb_wconv_sync_fifo.sv
// Bench for wconv_sync_fifo: directed vectors plus a short random burst.
// Stimulus pushes expected narrow words into a queue when a read is accepted;
// an independent monitor pops and compares dout on the falling edge.
module tb_wconv_sync_fifo;
  localparam int DIN_W  = 64;
  localparam int RATIO  = 2;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;
  localparam int DOUT_W = DIN_W / RATIO;
  localparam int WC_W   = $clog2(DEPTH + 1);
  localparam int RC_W   = $clog2(DEPTH * RATIO + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wconv_sync_fifo_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .WC_W(WC_W), .RC_W(RC_W)) bus ();

  wconv_sync_fifo #(.DIN_W(DIN_W), .RATIO(RATIO), .DEPTH(DEPTH),
                    .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DOUT_W-1:0] m_q[$];    // model: narrow words available
  logic [DOUT_W-1:0] exp_q[$];  // scoreboard: expected dout per accepted read
  int m_wc  = 0;
  int m_idx = 0;
  bit m_ovf = 0, m_unf = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: one expected word is queued per accepted read, just after the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("dout", 64'(bus.dout), 64'(exp_q.pop_front()));
  end

  task automatic chk_state();
    chk("wr_count",     64'(bus.wr_count),     64'(m_wc));
    chk("rd_count",     64'(bus.rd_count),     64'(m_q.size()));
    chk("full",         64'(bus.full),         64'(m_wc == DEPTH));
    chk("almost_full",  64'(bus.almost_full),  64'(m_wc >= AF));
    chk("empty",        64'(bus.empty),        64'(m_q.size() == 0));
    chk("almost_empty", 64'(bus.almost_empty), 64'(m_q.size() <= AE));
`ifdef WCONV_ERR_FLAGS_EN
    chk("overflow",     64'(bus.overflow),     64'(m_ovf));
    chk("underflow",    64'(bus.underflow),    64'(m_unf));
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, check.
  task automatic cyc(input bit w, input logic [DIN_W-1:0] d, input bit r);
    bit wa, ra;
    bus.din   = d;
    bus.wr_en = w;
    bus.rd_en = r;
    wa = w && (m_wc != DEPTH);
    ra = r && (m_q.size() != 0);
    if (w && !wa) m_ovf = 1;
    if (r && !ra) m_unf = 1;
    @(posedge clk); #1;
    if (ra) begin
      exp_q.push_back(m_q.pop_front());
      if (m_idx == RATIO - 1) begin m_idx = 0; m_wc--; end
      else m_idx++;
    end
    if (wa) begin
      for (int k = 0; k < RATIO; k++) m_q.push_back(d[DIN_W-1-k*DOUT_W -: DOUT_W]);
      m_wc++;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk_state();
  endtask

  // Reset with requests asserted: they must be ignored.
  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din   = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_wc = 0; m_idx = 0; m_ovf = 0; m_unf = 0;
    chk("rst_dout", 64'(bus.dout), 64'h0);
    chk_state();
  endtask

  initial begin
    bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) cyc(0, '0, 0);
    chk("idle_dout", 64'(bus.dout), 64'h0);
    chk("idle_empty", 64'(bus.empty), 64'h1);

    // Single wide word split into two narrow words, MS first.
    cyc(1, 64'h11111111_22222222, 0);
    chk("wc_after_wr", 64'(bus.wr_count), 64'd1);
    cyc(0, '0, 1);
    chk("rd0_dout", 64'(bus.dout), 64'h11111111);
    chk("wc_after_rd0", 64'(bus.wr_count), 64'd1);
    cyc(0, '0, 1);
    chk("rd1_dout", 64'(bus.dout), 64'h22222222);
    chk("wc_after_rd1", 64'(bus.wr_count), 64'd0);
    chk("empty_after_rd1", 64'(bus.empty), 64'h1);
    cyc(0, '0, 1);  // read while empty: ignored, dout holds
    chk("dout_hold", 64'(bus.dout), 64'h22222222);

    // Fill to full across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, {32'(i) | 32'hA000_0000, ~32'(i)}, 0);
      if (i == AF - 2) chk("af_below", 64'(bus.almost_full), 64'h0);
      if (i == AF - 1) chk("af_at", 64'(bus.almost_full), 64'h1);
    end
    chk("full_at_16", 64'(bus.full), 64'h1);
    cyc(1, 64'hBAD0_BAD0_BAD0_BAD0, 0);  // 17th write refused
    chk("wc_full_hold", 64'(bus.wr_count), 64'd16);

    // Held full, read the first half, then read last half + write together.
    cyc(0, '0, 1);
    cyc(1, 64'hAAAA_AAAA_5555_5555, 1);
    chk("wc_simul_rej", 64'(bus.wr_count), 64'd15);
    cyc(1, 64'hBBBB_BBBB_CCCC_CCCC, 0);
    chk("wc_next_acc", 64'(bus.wr_count), 64'd16);

    // Drain everything.
    for (int i = 0; i < 40 && m_q.size() > 0; i++) cyc(0, '0, 1);
    chk("drained_empty", 64'(bus.empty), 64'h1);

    // Reset mid-operation with 7 entries and a half-read word.
    for (int i = 0; i < 7; i++) cyc(1, {32'h7000_0000 + 32'(i), 32'h0700_0000 + 32'(i)}, 0);
    cyc(0, '0, 1);
    do_reset();
    cyc(1, 64'h1234_5678_9ABC_DEF0, 0);
    cyc(0, '0, 1);
    chk("post_rst_rd0", 64'(bus.dout), 64'h12345678);
    cyc(0, '0, 1);
    chk("post_rst_rd1", 64'(bus.dout), 64'h9ABCDEF0);

    // Concurrent random traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 2) == 0), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 40 && m_q.size() > 0; i++) cyc(0, '0, 1);

    @(posedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
